// File: rtl/mem_rd_cmd_engine.sv
// rtl/mem_rd_cmd_engine.sv - splits {address,length} read commands into 4 KB-safe AXI4 INCR bursts
// and frames the returned data as a keep/last stream followed by a one-byte completion.
module mem_rd_cmd_engine #(
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_BURST_BEATS = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic [63:0]               s_cmd_addr_i,
  input  logic [31:0]               s_cmd_len_i,
  input  logic                      s_cmd_tvalid_i,
  output logic                      s_cmd_tready_o,

  output logic                      m_axi_arid_o,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr_o,
  output logic [7:0]                m_axi_arlen_o,
  output logic [2:0]                m_axi_arsize_o,
  output logic [1:0]                m_axi_arburst_o,
  output logic [3:0]                m_axi_arcache_o,
  output logic [2:0]                m_axi_arprot_o,
  output logic                      m_axi_arlock_o,
  output logic [3:0]                m_axi_arqos_o,
  output logic [3:0]                m_axi_arregion_o,
  output logic                      m_axi_aruser_o,
  output logic                      m_axi_arvalid_o,
  input  logic                      m_axi_arready_i,

  input  logic                      m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata_i,
  input  logic [1:0]                m_axi_rresp_i,
  input  logic                      m_axi_rlast_i,
  input  logic                      m_axi_rvalid_i,
  output logic                      m_axi_rready_o,

  output logic                      m_axi_awid_o,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr_o,
  output logic [7:0]                m_axi_awlen_o,
  output logic [2:0]                m_axi_awsize_o,
  output logic [1:0]                m_axi_awburst_o,
  output logic [3:0]                m_axi_awcache_o,
  output logic [2:0]                m_axi_awprot_o,
  output logic                      m_axi_awlock_o,
  output logic [3:0]                m_axi_awqos_o,
  output logic [3:0]                m_axi_awregion_o,
  output logic                      m_axi_awuser_o,
  output logic                      m_axi_awvalid_o,
  input  logic                      m_axi_awready_i,

  output logic [DATA_WIDTH-1:0]     m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb_o,
  output logic                      m_axi_wlast_o,
  output logic                      m_axi_wvalid_o,
  input  logic                      m_axi_wready_i,

  input  logic                      m_axi_bid_i,
  input  logic [1:0]                m_axi_bresp_i,
  input  logic                      m_axi_bvalid_i,
  output logic                      m_axi_bready_o,

  output logic [DATA_WIDTH-1:0]     m_data_tdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_data_tkeep_o,
  output logic                      m_data_tlast_o,
  output logic                      m_data_tvalid_o,
  input  logic                      m_data_tready_i,

  output logic [7:0]                m_status_tdata_o,
  output logic                      m_status_tvalid_o,
  input  logic                      m_status_tready_i
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int LEFT_W = 33 - OFF_W;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int NW     = 13;
  localparam logic [NW-1:0] BURST_MAX = NW'(MAX_BURST_BEATS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STATUS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEFT_W-1:0]     ar_left_q, ar_left_d;
  logic [LEFT_W-1:0]     r_left_q, r_left_d;
  logic [OFF_W-1:0]      tail_q, tail_d;
  logic                  err_q, err_d;
  logic                  decerr_q, decerr_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [NW-1:0]         ar_n_q, ar_n_d;

  logic                  cmd_hs, ar_hs, r_hs, r_final;
  logic [LEFT_W-1:0]     beats_total;
  logic [NW-1:0]         boundary_beats, n_d;
  logic [BYTES-1:0]      all_ones;

  assign all_ones    = '1;
  assign beats_total = LEFT_W'((33'(s_cmd_len_i) + 33'(BYTES - 1)) >> OFF_W);

  assign s_cmd_tready_o = (state_q == ST_IDLE) && !rst_i;
  assign cmd_hs         = s_cmd_tready_o && s_cmd_tvalid_i;
  assign ar_hs          = arvalid_q && m_axi_arready_i;
  assign r_hs           = m_axi_rvalid_i && m_axi_rready_o;
  assign r_final        = (r_left_q == LEFT_W'(1));

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    ar_left_d      = ar_left_q;
    r_left_d       = r_left_q;
    tail_d         = tail_q;
    err_d          = err_q;
    decerr_d       = decerr_q;
    arvalid_d      = arvalid_q;
    araddr_d       = araddr_q;
    arlen_d        = arlen_q;
    ar_n_d         = ar_n_q;
    outstanding_d  = outstanding_q + OUT_W'(ar_hs) - OUT_W'(r_hs && m_axi_rlast_i);
    boundary_beats = '0;
    n_d            = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          addr_d    = {s_cmd_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          ar_left_d = beats_total;
          r_left_d  = beats_total;
          tail_d    = s_cmd_len_i[OFF_W-1:0];
          err_d     = 1'b0;
          decerr_d  = 1'b0;
          state_d   = (s_cmd_len_i == '0) ? ST_STATUS : ST_RUN;
        end
      end
      ST_RUN: begin
        if (ar_hs) begin
          addr_d    = addr_q + (ADDR_WIDTH'(ar_n_q) << OFF_W);
          ar_left_d = ar_left_q - LEFT_W'(ar_n_q);
        end
        if (r_hs) begin
          r_left_d = r_left_q - LEFT_W'(1);
          if (m_axi_rresp_i != 2'b00) err_d = 1'b1;
          if (m_axi_rresp_i == 2'b11) decerr_d = 1'b1;
          if (r_final) state_d = ST_STATUS;
        end
      end
      ST_STATUS: begin
        if (m_status_tready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ar_hs) arvalid_d = 1'b0;

    // Burst size is chosen from the post-handshake address so a new AR can follow immediately.
    boundary_beats = NW'((13'd4096 - {1'b0, addr_d[11:0]}) >> OFF_W);
    n_d = BURST_MAX;
    if (boundary_beats < n_d) n_d = boundary_beats;
    if (ar_left_d < LEFT_W'(n_d)) n_d = NW'(ar_left_d);

    if ((state_d == ST_RUN) && (ar_left_d != '0) &&
        (outstanding_d < OUT_W'(MAX_OUTSTANDING)) && (!arvalid_q || ar_hs)) begin
      arvalid_d = 1'b1;
      araddr_d  = addr_d;
      arlen_d   = 8'(n_d - NW'(1));
      ar_n_d    = n_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      ar_left_q     <= '0;
      r_left_q      <= '0;
      tail_q        <= '0;
      err_q         <= 1'b0;
      decerr_q      <= 1'b0;
      outstanding_q <= '0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      ar_n_q        <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ar_left_q     <= ar_left_d;
      r_left_q      <= r_left_d;
      tail_q        <= tail_d;
      err_q         <= err_d;
      decerr_q      <= decerr_d;
      outstanding_q <= outstanding_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      ar_n_q        <= ar_n_d;
    end
  end

  assign m_axi_arid_o     = 1'b0;
  assign m_axi_araddr_o   = araddr_q;
  assign m_axi_arlen_o    = arlen_q;
  assign m_axi_arsize_o   = 3'(OFF_W);
  assign m_axi_arburst_o  = 2'b01;
  assign m_axi_arcache_o  = 4'b0011;
  assign m_axi_arprot_o   = 3'b000;
  assign m_axi_arlock_o   = 1'b0;
  assign m_axi_arqos_o    = 4'b0000;
  assign m_axi_arregion_o = 4'b0000;
  assign m_axi_aruser_o   = 1'b0;
  assign m_axi_arvalid_o  = arvalid_q;

  // Stream framing follows the command's beat count; rlast only drives outstanding accounting.
  assign m_axi_rready_o  = (state_q == ST_RUN) && m_data_tready_i;
  assign m_data_tvalid_o = (state_q == ST_RUN) && m_axi_rvalid_i;
  assign m_data_tdata_o  = m_axi_rdata_i;
  assign m_data_tlast_o  = (state_q == ST_RUN) && r_final;
  assign m_data_tkeep_o  = (r_final && (tail_q != '0)) ? ~(all_ones << tail_q) : all_ones;

  assign m_status_tvalid_o = (state_q == ST_STATUS);
  assign m_status_tdata_o  = {6'b0, decerr_q, err_q};

  assign m_axi_awid_o     = 1'b0;
  assign m_axi_awaddr_o   = '0;
  assign m_axi_awlen_o    = 8'd0;
  assign m_axi_awsize_o   = 3'd0;
  assign m_axi_awburst_o  = 2'd0;
  assign m_axi_awcache_o  = 4'd0;
  assign m_axi_awprot_o   = 3'd0;
  assign m_axi_awlock_o   = 1'b0;
  assign m_axi_awqos_o    = 4'd0;
  assign m_axi_awregion_o = 4'd0;
  assign m_axi_awuser_o   = 1'b0;
  assign m_axi_awvalid_o  = 1'b0;
  assign m_axi_wdata_o    = '0;
  assign m_axi_wstrb_o    = '0;
  assign m_axi_wlast_o    = 1'b0;
  assign m_axi_wvalid_o   = 1'b0;
  assign m_axi_bready_o   = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{s_cmd_addr_i[63:ADDR_WIDTH], s_cmd_addr_i[OFF_W-1:0], m_axi_rid_i,
                           m_axi_awready_i, m_axi_wready_i, m_axi_bid_i, m_axi_bresp_i,
                           m_axi_bvalid_i};

endmodule

// File: tb/tb_mem_rd_cmd_engine.sv
// tb/tb_mem_rd_cmd_engine.sv - directed bench for mem_rd_cmd_engine with a small AXI read slave
module tb_mem_rd_cmd_engine;
  localparam int AW = 33;
  localparam int DW = 256;
  localparam int BY = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] cmd_addr;
  logic [31:0] cmd_len;
  logic cmd_valid, cmd_ready;
  logic arid, arlock, aruser, arvalid, arready;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst;
  logic [3:0] arcache, arqos, arregion;
  logic rid, rlast, rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic awid, awlock, awuser, awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst;
  logic [3:0] awcache, awqos, awregion;
  logic [DW-1:0] wdata;
  logic [BY-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic bid, bvalid, bready;
  logic [1:0] bresp;
  logic [DW-1:0] d_data;
  logic [BY-1:0] d_keep;
  logic d_last, d_valid, d_ready;
  logic [7:0] st_data;
  logic st_valid, st_ready;

  mem_rd_cmd_engine dut (
    .clk_i(clk), .rst_i(rst),
    .s_cmd_addr_i(cmd_addr), .s_cmd_len_i(cmd_len), .s_cmd_tvalid_i(cmd_valid), .s_cmd_tready_o(cmd_ready),
    .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
    .m_axi_arburst_o(arburst), .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot), .m_axi_arlock_o(arlock),
    .m_axi_arqos_o(arqos), .m_axi_arregion_o(arregion), .m_axi_aruser_o(aruser),
    .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
    .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
    .m_axi_awburst_o(awburst), .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awlock_o(awlock),
    .m_axi_awqos_o(awqos), .m_axi_awregion_o(awregion), .m_axi_awuser_o(awuser),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast), .m_axi_wvalid_o(wvalid),
    .m_axi_wready_i(wready),
    .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_data_tdata_o(d_data), .m_data_tkeep_o(d_keep), .m_data_tlast_o(d_last),
    .m_data_tvalid_o(d_valid), .m_data_tready_i(d_ready),
    .m_status_tdata_o(st_data), .m_status_tvalid_o(st_valid), .m_status_tready_i(st_ready)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int tb_out = 0;
  int slave_delay = 0;
  logic [31:0] err_addr = '1;
  logic [1:0] resp_code = 2'b00;
  logic bp_en = 1'b0;

  logic [AW-1:0] ar_addr_log[$];
  logic [7:0]    ar_len_log[$];
  int            out_log[$];
  logic [DW-1:0] bt_data[$];
  logic [BY-1:0] bt_keep[$];
  logic          bt_last[$];
  int            bt_cyc[$];
  logic [7:0]    st_log[$];
  int            st_cyc[$];

  function automatic logic [DW-1:0] exp_data(input logic [31:0] a);
    return {8{a}};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Handshakes are logged at the falling edge, where the pending posedge outcome is stable.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      tb_out = 0;
    end else begin
      if (arvalid && arready) begin
        ar_addr_log.push_back(araddr);
        ar_len_log.push_back(arlen);
        tb_out++;
        out_log.push_back(tb_out);
      end
      if (rvalid && rready && rlast) tb_out--;
      if (d_valid && d_ready) begin
        bt_data.push_back(d_data); bt_keep.push_back(d_keep);
        bt_last.push_back(d_last); bt_cyc.push_back(cyc);
      end
      if (st_valid && st_ready) begin
        st_log.push_back(st_data); st_cyc.push_back(cyc);
      end
    end
  end

  initial begin : r_slave
    int r_idx;
    logic [31:0] a;
    logic [7:0] l;
    bit aborted, hs;
    r_idx = 0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_idx = ar_addr_log.size();
      end else if (r_idx < ar_addr_log.size()) begin
        a = ar_addr_log[r_idx][31:0];
        l = ar_len_log[r_idx];
        r_idx++;
        aborted = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < slave_delay && !aborted; d++) begin
          @(negedge clk); if (rst) aborted = 1'b1;
          @(posedge clk); #1;
        end
        for (int b = 0; b <= int'(l) && !aborted; b++) begin
          rvalid = 1'b1;
          rdata  = exp_data(a + 32'(b * 32));
          rlast  = (b == int'(l));
          rresp  = ((a + 32'(b * 32)) == err_addr) ? resp_code : 2'b00;
          hs = 1'b0;
          for (int w = 0; w < 2000 && !hs && !aborted; w++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
            hs = rready;
            @(posedge clk); #1;
          end
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        if (aborted) r_idx = ar_addr_log.size();
      end
    end
  end

  initial begin
    d_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) d_ready = ~d_ready;
      else d_ready = 1'b1;
    end
  end

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, output bit ok);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_status(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (st_log.size() > base) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fails++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_checks++; if ({arvalid, d_valid, st_valid} !== 3'b000) begin n_fails++; $display("FAIL reset_valids: got %b want 000", {arvalid, d_valid, st_valid}); end
    n_checks++; if ({bready, awvalid, wvalid} !== 3'b100) begin n_fails++; $display("FAIL reset_write_tieoff: got %b want 100", {bready, awvalid, wvalid}); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL reset_idle_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_beat();
    int b_bt, b_st, b_ar;
    bit ok;
    b_bt = bt_data.size(); b_st = st_log.size(); b_ar = ar_addr_log.size();
    send_cmd(64'h1000, 32'd32, ok);
    n_checks++; if ({ok, arvalid} !== 2'b11) begin n_fails++; $display("FAIL single_ar_latency: got ok,arvalid=%b want 11", {ok, arvalid}); end
    n_checks++; if ({arid, arsize, arburst, arcache, arprot, arlock, arqos, arregion, aruser} !== {1'b0, 3'b101, 2'b01, 4'b0011, 3'b0, 1'b0, 4'b0, 4'b0, 1'b0}) begin
      n_fails++; $display("FAIL single_ar_fields: got size=%0d burst=%0d cache=%0h", arsize, arburst, arcache); end
    wait_status(b_st, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL single_status_timeout: got none want status"); end
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL single_next_ready: got %b want 1", cmd_ready); end
    n_checks++; if (ar_addr_log.size() != b_ar + 1 || ar_addr_log[b_ar] !== 33'h1000 || ar_len_log[b_ar] !== 8'd0) begin
      n_fails++; $display("FAIL single_ar: got n=%0d want 1 AR 0x1000 len 0", ar_addr_log.size() - b_ar); end
    n_checks++; if (bt_data.size() != b_bt + 1 || bt_data[b_bt] !== exp_data(32'h1000) || bt_keep[b_bt] !== 32'hFFFF_FFFF || bt_last[b_bt] !== 1'b1) begin
      n_fails++; $display("FAIL single_beat: got n=%0d want one full last beat", bt_data.size() - b_bt); end
    if (ok && bt_data.size() > b_bt) begin
      n_checks++; if (st_log[b_st] !== 8'h00 || st_cyc[b_st] != bt_cyc[b_bt] + 1) begin
        n_fails++; $display("FAIL single_status: got %h at +%0d want 00 at +1", st_log[b_st], st_cyc[b_st] - bt_cyc[b_bt]); end
    end
  endtask

  task automatic test_partial_tail();
    int b_bt, b_st, b_ar;
    bit ok;
    b_bt = bt_data.size(); b_st = st_log.size(); b_ar = ar_addr_log.size();
    send_cmd(64'h0, 32'd100, ok);
    wait_status(b_st, ok);
    n_checks++; if (!ok || st_log[b_st] !== 8'h00) begin n_fails++; $display("FAIL tail_status: got ok=%0d want status 00", ok); end
    n_checks++; if (ar_addr_log.size() != b_ar + 1 || ar_len_log[b_ar] !== 8'd3) begin n_fails++; $display("FAIL tail_ar: got %0d ARs want one arlen 3", ar_addr_log.size() - b_ar); end
    n_checks++; if (bt_data.size() != b_bt + 4) begin n_fails++; $display("FAIL tail_count: got %0d want 4", bt_data.size() - b_bt); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bt_data[b_bt+i] !== exp_data(32'(i * 32)) || bt_last[b_bt+i] !== (i == 3) ||
          bt_keep[b_bt+i] !== ((i == 3) ? 32'h0000_000F : 32'hFFFF_FFFF)) begin
        n_fails++; $display("FAIL tail_beat%0d: got keep=%h last=%b", i, bt_keep[b_bt+i], bt_last[b_bt+i]); end
    end
  endtask

  task automatic test_4k_split();
    int b_bt, b_st, b_ar;
    bit ok;
    b_bt = bt_data.size(); b_st = st_log.size(); b_ar = ar_addr_log.size();
    send_cmd(64'hFC0, 32'd128, ok);
    wait_status(b_st, ok);
    n_checks++; if (!ok || st_log[b_st] !== 8'h00) begin n_fails++; $display("FAIL split_status: got ok=%0d want status 00", ok); end
    n_checks++; if (ar_addr_log.size() != b_ar + 2 || ar_addr_log[b_ar] !== 33'hFC0 || ar_len_log[b_ar] !== 8'd1 ||
                    ar_addr_log[b_ar+1] !== 33'h1000 || ar_len_log[b_ar+1] !== 8'd1) begin
      n_fails++; $display("FAIL split_ars: got %0d ARs want (FC0,1)(1000,1)", ar_addr_log.size() - b_ar); end
    n_checks++; if (bt_data.size() != b_bt + 4 || {bt_last[b_bt], bt_last[b_bt+1], bt_last[b_bt+2], bt_last[b_bt+3]} !== 4'b0001 ||
                    bt_data[b_bt+3] !== exp_data(32'h1020)) begin
      n_fails++; $display("FAIL split_beats: got %0d beats want 4 with last on 4th", bt_data.size() - b_bt); end
  endtask

  task automatic test_outstanding();
    int b_bt, b_st, b_ar, bad, max_out;
    bit ok;
    b_bt = bt_data.size(); b_st = st_log.size(); b_ar = ar_addr_log.size();
    slave_delay = 50;
    send_cmd(64'h0, 32'd16384, ok);
    wait_status(b_st, ok);
    slave_delay = 0;
    n_checks++; if (!ok || st_log[b_st] !== 8'h00) begin n_fails++; $display("FAIL long_status: got ok=%0d want status 00", ok); end
    bad = 0; max_out = 0;
    for (int i = b_ar; i < ar_addr_log.size(); i++) begin
      if (ar_len_log[i] !== 8'd63 || ar_addr_log[i] !== 33'((i - b_ar) * 2048)) bad++;
      if (out_log[i] > max_out) max_out = out_log[i];
    end
    n_checks++; if (ar_addr_log.size() != b_ar + 8 || bad != 0) begin n_fails++; $display("FAIL long_ars: got %0d ARs %0d bad want 8 arlen 63", ar_addr_log.size() - b_ar, bad); end
    n_checks++; if (max_out != 4) begin n_fails++; $display("FAIL long_outstanding: got max %0d want 4", max_out); end
    bad = 0;
    for (int i = b_bt; i < bt_data.size(); i++)
      if (bt_data[i] !== exp_data(32'((i - b_bt) * 32)) || bt_keep[i] !== 32'hFFFF_FFFF || bt_last[i] !== (i == b_bt + 511)) bad++;
    n_checks++; if (bt_data.size() != b_bt + 512 || bad != 0) begin n_fails++; $display("FAIL long_beats: got %0d beats %0d bad want 512", bt_data.size() - b_bt, bad); end
  endtask

  task automatic test_error();
    int b_bt, b_st;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      b_bt = bt_data.size(); b_st = st_log.size();
      err_addr = 32'h2000;
      resp_code = (k == 0) ? 2'b10 : 2'b11;
      send_cmd(64'h2000, 32'd64, ok);
      wait_status(b_st, ok);
      err_addr = '1;
      n_checks++; if (!ok || st_log[b_st] !== ((k == 0) ? 8'h01 : 8'h03)) begin
        n_fails++; $display("FAIL err_status%0d: got %h want %h", k, ok ? st_log[b_st] : 8'hxx, (k == 0) ? 8'h01 : 8'h03); end
      n_checks++; if (bt_data.size() != b_bt + 2 || bt_data[b_bt+1] !== exp_data(32'h2020)) begin
        n_fails++; $display("FAIL err_beats%0d: got %0d want 2", k, bt_data.size() - b_bt); end
    end
  endtask

  task automatic test_backpressure();
    int b_bt, b_st, bad;
    bit ok;
    b_bt = bt_data.size(); b_st = st_log.size();
    bp_en = 1'b1;
    send_cmd(64'h6000, 32'd160, ok);
    wait_status(b_st, ok);
    bp_en = 1'b0;
    bad = 0;
    for (int i = b_bt; i < bt_data.size(); i++)
      if (bt_data[i] !== exp_data(32'h6000 + 32'((i - b_bt) * 32)) || bt_last[i] !== (i == b_bt + 4)) bad++;
    n_checks++; if (!ok || bt_data.size() != b_bt + 5 || bad != 0) begin
      n_fails++; $display("FAIL bp_beats: got %0d beats %0d bad want 5 in order", bt_data.size() - b_bt, bad); end
  endtask

  task automatic test_len_zero();
    int b_bt, b_st, b_ar;
    bit ok;
    b_bt = bt_data.size(); b_st = st_log.size(); b_ar = ar_addr_log.size();
    send_cmd(64'h40, 32'd0, ok);
    n_checks++; if ({ok, st_valid, arvalid} !== 3'b110 || st_data !== 8'h00) begin
      n_fails++; $display("FAIL zero_status_latency: got ok,stv,arv=%b data=%h want 110 00", {ok, st_valid, arvalid}, st_data); end
    wait_status(b_st, ok);
    n_checks++; if (!ok || ar_addr_log.size() != b_ar || bt_data.size() != b_bt) begin
      n_fails++; $display("FAIL zero_no_traffic: got %0d ARs %0d beats want 0 0", ar_addr_log.size() - b_ar, bt_data.size() - b_bt); end
  endtask

  task automatic test_reset_mid_run();
    int b_bt, b_st, b_ar;
    bit ok;
    slave_delay = 20;
    send_cmd(64'h3000, 32'd256, ok);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({arvalid, d_valid, st_valid, cmd_ready} !== 4'b0000) begin
      n_fails++; $display("FAIL rst_mid_valids: got %b want 0000", {arvalid, d_valid, st_valid, cmd_ready}); end
    rst = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL rst_mid_idle: got %b want 1", cmd_ready); end
    repeat (30) @(posedge clk);
    slave_delay = 0;
    b_bt = bt_data.size(); b_st = st_log.size(); b_ar = ar_addr_log.size();
    send_cmd(64'h5000, 32'd64, ok);
    wait_status(b_st, ok);
    n_checks++; if (!ok || st_log[b_st] !== 8'h00 || ar_addr_log.size() != b_ar + 1 || ar_addr_log[b_ar] !== 33'h5000) begin
      n_fails++; $display("FAIL rst_next_cmd: got ok=%0d ARs=%0d want status 00 one AR", ok, ar_addr_log.size() - b_ar); end
    n_checks++; if (bt_data.size() != b_bt + 2 || bt_data[b_bt] !== exp_data(32'h5000) || bt_last[b_bt+1] !== 1'b1) begin
      n_fails++; $display("FAIL rst_next_beats: got %0d want 2", bt_data.size() - b_bt); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    arready = 1'b1; awready = 1'b0; wready = 1'b0;
    bid = 1'b0; bresp = 2'b00; bvalid = 1'b0; st_ready = 1'b1;
    test_reset();
    test_single_beat();
    test_partial_tail();
    test_4k_split();
    test_outstanding();
    test_error();
    test_backpressure();
    test_len_zero();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
